// File: rtl/adc_ad7944_pkg.sv
// Shared types and constants for the AD7944 responder model.
package adc_ad7944_pkg;

  localparam int DATA_WIDTH_DEF = 14;

  localparam logic [13:0] ALT_A = 14'h2AAA;
  localparam logic [13:0] ALT_B = 14'h1555;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_WAIT,
    S_READ
  } state_t;

  typedef enum logic [1:0] {
    MODE_CONST = 2'b00,
    MODE_RAMP  = 2'b01,
    MODE_ALT   = 2'b10,
    MODE_EXT   = 2'b11
  } mode_t;

endpackage

// File: rtl/adc_ad7944_pattern_gen.sv
// Conversion word source: constant, ramp, alternating or external word.
// Ramp and alternate state only advance when their own mode is the one consumed.
module adc_ad7944_pattern_gen
  import adc_ad7944_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_data,
  input  logic [DATA_WIDTH-1:0] ext_data,
  output logic [DATA_WIDTH-1:0] word
);

  logic [DATA_WIDTH-1:0] ramp;
  logic                  alt_sel;

  always_comb begin
    word = const_data;
    case (mode)
      MODE_RAMP: word = ramp;
      MODE_ALT:  word = alt_sel ? DATA_WIDTH'(ALT_B) : DATA_WIDTH'(ALT_A);
      MODE_EXT:  word = ext_data;
      default:   word = const_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ramp    <= '0;
      alt_sel <= 1'b0;
    end else if (next) begin
      if (mode == MODE_RAMP) ramp <= ramp + DATA_WIDTH'(1);
      if (mode == MODE_ALT)  alt_sel <= ~alt_sel;
    end
  end

endmodule

// File: rtl/adc_ad7944_emulator.sv
// AD7944 responder: answers CNV with a timed conversion and an MSB-first
// serial word on Sdo, flagging early and truncated reads.
module adc_ad7944_emulator
  import adc_ad7944_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int TCONV_CYC       = 21,
  parameter int TCONV_TURBO_CYC = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_N,
  input  logic                  CNV,
  input  logic                  Turb,
  input  logic [1:0]            Mode,
  input  logic [DATA_WIDTH-1:0] In_Const_Data,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  Sdo,
  output logic                  Busy,
  output logic                  Read_Done,
  output logic                  Err_Early,
  output logic                  Err_Short,
  output logic [15:0]           Conv_Cnt
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [7:0] TC_NORM  = 8'(TCONV_CYC);
  localparam logic [7:0] TC_TURBO = 8'(TCONV_TURBO_CYC);

  state_t                state;
  logic                  cnv_d;
  logic                  rise;
  logic [7:0]            cnt;
  logic [7:0]            tc;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] conv_word;
  logic [DATA_WIDTH-1:0] src_word;
  logic [BW-1:0]         bit_cnt;

  assign rise = CNV & ~cnv_d;
  assign Sdo  = ~CNV & shreg[DATA_WIDTH-1];

  adc_ad7944_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern_gen (
    .clk       (Clk),
    .rst_n     (Rst_N),
    .next      (rise),
    .mode      (Mode),
    .const_data(In_Const_Data),
    .ext_data  (In_Data),
    .word      (src_word)
  );

  // A rise restarts the conversion from any state; everything else is the read protocol.
  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      state     <= S_IDLE;
      cnv_d     <= 1'b0;
      cnt       <= '0;
      tc        <= '0;
      shreg     <= '0;
      conv_word <= '0;
      bit_cnt   <= '0;
      Conv_Cnt  <= '0;
      Busy      <= 1'b0;
      Read_Done <= 1'b0;
      Err_Early <= 1'b0;
      Err_Short <= 1'b0;
    end else begin
      cnv_d     <= CNV;
      Read_Done <= 1'b0;
      Err_Early <= 1'b0;
      Err_Short <= 1'b0;
      if (rise) begin
        Err_Short <= (state == S_READ) && (bit_cnt < BW'(DATA_WIDTH));
        state     <= S_CONV;
        Busy      <= 1'b1;
        cnt       <= '0;
        shreg     <= '0;
        conv_word <= src_word;
        tc        <= Turb ? TC_TURBO : TC_NORM;
      end else begin
        case (state)
          S_CONV: begin
            if (CNV) begin
              cnt <= cnt + 8'd1;
              if (cnt == tc - 8'd1) begin
                shreg    <= conv_word;
                Conv_Cnt <= Conv_Cnt + 16'd1;
                state    <= S_WAIT;
                Busy     <= 1'b0;
              end
            end else begin
              Err_Early <= 1'b1;
              Busy      <= 1'b0;
              bit_cnt   <= '0;
              state     <= S_READ;
            end
          end
          S_WAIT: begin
            if (!CNV) begin
              shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt <= BW'(1);
              state   <= S_READ;
            end
          end
          S_READ: begin
            if (!CNV && (bit_cnt < BW'(DATA_WIDTH))) begin
              shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BW'(DATA_WIDTH - 1)) Read_Done <= 1'b1;
            end
          end
          S_IDLE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
